// File: rtl/clkdiv_sched.sv
// Run-time clock divider: divided square wave q plus one-cycle period tick.
// Divisor updates and stops are deferred to period boundaries so q never runts.
module clkdiv_sched #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             q,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] div_act, div_act_nx;
    logic [WIDTH-1:0] div_pnd, div_pnd_nx;
    logic             pend, pend_nx;
    logic             err_nx;
    logic             last;
    logic             wrap;
    logic             xfer;
    logic             legal;

    // cfg handshake: a transfer happens on a rising edge with cfg_valid & cfg_ready;
    // cfg_ready drops while a divisor is parked waiting for the next wrap.
    assign last  = (cnt == div_act - WIDTH'(1));
    assign wrap  = (state != IDLE) && last;
    assign xfer  = cfg_valid && !pend;
    assign legal = (cfg_div >= WIDTH'(2));

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state   <= IDLE;
            cnt     <= '0;
            div_act <= WIDTH'(DEFAULT_DIV);
            div_pnd <= '0;
            pend    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            div_act <= div_act_nx;
            div_pnd <= div_pnd_nx;
            pend    <= pend_nx;
            cfg_err <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        div_act_nx = div_act;
        div_pnd_nx = div_pnd;
        pend_nx    = pend;
        err_nx     = xfer && !legal;

        case (state)
            IDLE:    if (run) state_nx = RUN;
            RUN:     if (!run) state_nx = last ? IDLE : DRAIN;
            DRAIN: begin
                if (run)       state_nx = RUN;
                else if (last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (state != IDLE) cnt_nx = last ? '0 : cnt + WIDTH'(1);

        // xfer needs pend=0, so a wrap-time apply and a new park never collide;
        // a value parked on a wrap edge therefore waits for the following wrap.
        if (wrap && pend) begin
            div_act_nx = div_pnd;
            pend_nx    = 1'b0;
        end
        if (xfer && legal) begin
            if (state == IDLE) begin
                div_act_nx = cfg_div;
            end else begin
                div_pnd_nx = cfg_div;
                pend_nx    = 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign tick      = busy && last;
    assign q         = busy && (cnt < (div_act >> 1));
    assign cfg_ready = !pend;

endmodule

// File: tb/tb_clkdiv_sched.sv
// Bench for clkdiv_sched: per-cycle expected {busy,q,tick,cfg_ready,cfg_err}
// vectors are queued with the stimulus and compared one cycle-edge later.
module tb_clkdiv_sched;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             ar;
    logic             run;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             q;
    logic             tick;
    logic             busy;

    int         total = 0;
    int         bad   = 0;
    logic [4:0] exp_q[$];
    logic [4:0] got;
    logic [4:0] exp_v;

    clkdiv_sched #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
        .clk       (clk),
        .ar        (ar),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .q         (q),
        .tick      (tick),
        .busy      (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [4:0] pack_exp(string b, string qs, string t,
                                            string r, string e, int i);
        return {b[i] == "1", qs[i] == "1", t[i] == "1", r[i] == "1", e[i] == "1"};
    endfunction

    task automatic do_reset();
        ar        = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        @(posedge clk); #1;
        ar = 1'b1;
    endtask

    task automatic test_reset();
        ar        = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        @(posedge clk); #1;
        got = {busy, q, tick, cfg_ready, cfg_err};
        total++;
        if (got !== 5'b00010) begin
            bad++;
            $display("FAIL reset_hold got b/q/t/r/e=%b want=%b", got, 5'b00010);
        end
        ar = 1'b1;
        @(posedge clk); #1;
        got = {busy, q, tick, cfg_ready, cfg_err};
        total++;
        if (got !== 5'b00010) begin
            bad++;
            $display("FAIL reset_idle got b/q/t/r/e=%b want=%b", got, 5'b00010);
        end
    endtask

    task automatic test_basic();
        string rs = "0111111111111";
        string qs = "0110011001100";
        string ts = "0000100010001";
        string bs = "0111111111111";
        string es = "0000000000000";
        string ys = "1111111111111";
        do_reset();
        for (int i = 0; i < rs.len(); i++) begin
            run       = (rs[i] == "1");
            cfg_valid = 1'b0;
            exp_q.push_back(pack_exp(bs, qs, ts, ys, es, i));
            @(posedge clk); #1;
            got   = {busy, q, tick, cfg_ready, cfg_err};
            exp_v = exp_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL basic cyc=%0d got b/q/t/r/e=%b want=%b", i, got, exp_v);
            end
        end
    endtask

    task automatic test_reconfig();
        string vs = "001000000000";
        string qs = "110011100011";
        string ts = "000100000100";
        string ys = "110011111111";
        string bs = "111111111111";
        string es = "000000000000";
        do_reset();
        for (int i = 0; i < vs.len(); i++) begin
            run       = 1'b1;
            cfg_valid = (vs[i] == "1");
            cfg_div   = 16'd6;
            exp_q.push_back(pack_exp(bs, qs, ts, ys, es, i));
            @(posedge clk); #1;
            got   = {busy, q, tick, cfg_ready, cfg_err};
            exp_v = exp_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL reconfig cyc=%0d got b/q/t/r/e=%b want=%b", i, got, exp_v);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        string vs = "00001000000000";
        string qs = "11001100100100";
        string ts = "00010001001001";
        string ys = "11110000111111";
        string bs = "11111111111111";
        string es = "00000000000000";
        do_reset();
        for (int i = 0; i < vs.len(); i++) begin
            run       = 1'b1;
            cfg_valid = (vs[i] == "1");
            cfg_div   = 16'd3;
            exp_q.push_back(pack_exp(bs, qs, ts, ys, es, i));
            @(posedge clk); #1;
            got   = {busy, q, tick, cfg_ready, cfg_err};
            exp_v = exp_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL wrap_cfg cyc=%0d got b/q/t/r/e=%b want=%b", i, got, exp_v);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_illegal();
        string vs = "010100000";
        string qs = "110011001";
        string ts = "000100010";
        string ys = "111111111";
        string bs = "111111111";
        string es = "010100000";
        do_reset();
        for (int i = 0; i < vs.len(); i++) begin
            run       = 1'b1;
            cfg_valid = (vs[i] == "1");
            cfg_div   = (i == 1) ? 16'd1 : 16'd0;
            exp_q.push_back(pack_exp(bs, qs, ts, ys, es, i));
            @(posedge clk); #1;
            got   = {busy, q, tick, cfg_ready, cfg_err};
            exp_v = exp_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL illegal cyc=%0d got b/q/t/r/e=%b want=%b", i, got, exp_v);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_stop();
        string rs, qs, ts, bs;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin rs = "11000011"; qs = "11000011"; ts = "00010000"; bs = "11110011"; end
                1: begin rs = "11011111"; qs = "11001100"; ts = "00010001"; bs = "11111111"; end
                default: begin rs = "11110"; qs = "11000"; ts = "00010"; bs = "11110"; end
            endcase
            do_reset();
            for (int i = 0; i < rs.len(); i++) begin
                run       = (rs[i] == "1");
                cfg_valid = 1'b0;
                exp_q.push_back({bs[i] == "1", qs[i] == "1", ts[i] == "1", 1'b1, 1'b0});
                @(posedge clk); #1;
                got   = {busy, q, tick, cfg_ready, cfg_err};
                exp_v = exp_q.pop_front();
                total++;
                if (got !== exp_v) begin
                    bad++;
                    $display("FAIL stop s=%0d cyc=%0d got b/q/t/r/e=%b want=%b", s, i, got, exp_v);
                end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid();
        string vs = "01";
        string qs = "11";
        string ts = "00";
        string ys = "10";
        string bs = "11";
        string es = "00";
        string pq = "11001100";
        string pt = "00010001";
        do_reset();
        for (int i = 0; i < vs.len(); i++) begin
            run       = 1'b1;
            cfg_valid = (vs[i] == "1");
            cfg_div   = 16'd8;
            exp_q.push_back(pack_exp(bs, qs, ts, ys, es, i));
            @(posedge clk); #1;
            got   = {busy, q, tick, cfg_ready, cfg_err};
            exp_v = exp_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL pre_reset cyc=%0d got b/q/t/r/e=%b want=%b", i, got, exp_v);
            end
        end
        cfg_valid = 1'b0;
        #2 ar = 1'b0;
        #1;
        got = {busy, q, tick, cfg_ready, cfg_err};
        total++;
        if (got !== 5'b00010) begin
            bad++;
            $display("FAIL async_reset got b/q/t/r/e=%b want=%b", got, 5'b00010);
        end
        run = 1'b0;
        @(posedge clk); #1;
        ar = 1'b1;
        for (int i = 0; i < pq.len(); i++) begin
            run = 1'b1;
            exp_q.push_back({1'b1, pq[i] == "1", pt[i] == "1", 1'b1, 1'b0});
            @(posedge clk); #1;
            got   = {busy, q, tick, cfg_ready, cfg_err};
            exp_v = exp_q.pop_front();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL post_reset cyc=%0d got b/q/t/r/e=%b want=%b", i, got, exp_v);
            end
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reconfig();
        test_back_to_back();
        test_illegal();
        test_stop();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clkdiv_sched.md
Name: clkdiv_sched

Overview:
Run-time controller for the project's clock divider function. It generates a divided square wave plus a one-cycle period tick from a single system clock, with a start/stop control and a handshaked divisor-configuration port. Divisor changes and stops take effect only at period boundaries, so q never produces a runt pulse. Downstream logic uses q or tick as the divided clock or enable.

Parameters:
WIDTH, 16, bit width of divisor and period counter
DEFAULT_DIV, 4, divisor loaded at reset; must be >= 2 and < 2^WIDTH

Ports:
clk  in  1  system clock, all state on rising edge
ar  in  1  asynchronous active-low reset
run  in  1  level; 1 = generate output, 0 = stop at the next period boundary
cfg_valid  in  1  a divisor update is offered
cfg_div  in  WIDTH  offered divisor in clk cycles per output period
cfg_ready  out  1  update can be accepted; transfer occurs when cfg_valid & cfg_ready at a rising edge
cfg_err  out  1  one-cycle pulse: the accepted divisor was illegal (< 2) and was discarded
q  out  1  divided output
tick  out  1  high during the last clk cycle of each output period
busy  out  1  state != IDLE

Behaviour:
- Async reset (ar=0): state=IDLE, cnt=0, div_act=DEFAULT_DIV, pend=0, cfg_err=0. Outputs: q=0, tick=0, busy=0, cfg_ready=1.
- Outputs depend only on registers. There is no combinational path from any input to any output.
- States:
  - IDLE: cnt held at 0; q=0; tick=0.
  - RUN: counting.
  - DRAIN: finishing the current period after run falls.
- Transitions:
  - IDLE->RUN on the edge where run=1. The first RUN cycle has cnt=0.
  - RUN->DRAIN on an edge with run=0 and cnt != div_act-1.
  - RUN->IDLE on an edge with run=0 and cnt == div_act-1.
  - DRAIN->RUN if run=1 before the wrap; cnt continues without restarting.
  - DRAIN->IDLE at the wrap.
- Counter in RUN/DRAIN: cnt increments each cycle. When cnt == div_act-1, the next cnt is 0 (wrap).
- tick = (state!=IDLE) & (cnt == div_act-1).
- q = (state!=IDLE) & (cnt < (div_act>>1)). Period is div_act cycles, with floor(div_act/2) cycles high. Odd divisors are low for the longer half.
- Configuration:
  - cfg_ready = ~pend.
  - On a transfer with cfg_div < 2: nothing else changes and cfg_err=1 for the next cycle only.
  - Legal transfer in IDLE: div_act <= cfg_div next cycle.
  - Legal transfer in RUN/DRAIN: div_pnd <= cfg_div and pend <= 1.
- At a wrap with pend=1: div_act <= div_pnd, pend <= 0, cnt <= 0. The new period uses the new divisor, and cfg_ready returns to 1 the cycle after the wrap.
- Simultaneous transfer and wrap: the value goes to pend and is applied at the following wrap, not the current one.
- When entering IDLE with pend=1, the pending value is applied at that same wrap.
- run toggling while in IDLE for zero cycles has no effect beyond the state rules above.
- Reset mid-period: q and tick go to 0 immediately (asynchronous) and the pending update is lost.
- Widths: comparisons are unsigned WIDTH-bit. A divisor of 2^WIDTH-1 is legal. cnt never exceeds div_act-1.

Test Plan:
1. Reset with DEFAULT_DIV=4, then run=1 -> q repeats 1,1,0,0; tick high on every 4th cycle (cnt=3); busy=1 from the cycle after run rises.
2. While running div=4, transfer cfg_div=6 at cnt=1 -> cfg_ready=0 until the wrap; the remainder of the current period keeps div 4; the next period is q 1,1,1,0,0,0 with tick at cnt=5.
3. Transfer cfg_div=3 in the same cycle as a wrap (cnt=3, div 4) -> one more 4-cycle period, then 3-cycle periods (q 1,0,0).
4. Transfer cfg_div=1 and then cfg_div=0 while running -> cfg_err pulses one cycle each; period unchanged at 4; cfg_ready stays 1.
5. Drop run at cnt=1 (div 4) -> busy=1 through cnt=3, tick at cnt=3, then IDLE with q=0. Repeat, raising run at cnt=2 -> no stop occurs and the period is uninterrupted.
6. Assert ar low mid-period with a pending div=8 -> q=0, tick=0, cfg_ready=1 immediately. After release and run=1, periods are 4 cycles (DEFAULT_DIV) and the pending value is discarded.
